sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit single-ported SRAM between instruction fetch and the memory stage.
// Each 32-bit access runs as two halfword phases (LO then HI); freeze holds the pipeline meanwhile.
module sram_port_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    // Index of the last cycle of a phase; a phase lasts WAIT_CYCLES+1 cycles.
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q;
    logic                is_mem_q;
    logic [ADDR_W-2:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [15:0]         lo_q;
    logic                if_ready_q, mem_ready_q;
    logic [31:0]         if_rdata_q, mem_rdata_q;

    logic mem_req, mem_elig, if_elig, last, done_hit;

    assign mem_req  = mem_r_en | mem_w_en;
    assign mem_elig = mem_req & ~mem_ready_q;
    assign if_elig  = if_req & ~if_ready_q;
    assign last     = (cnt_q == LAST);
    assign done_hit = (state_q == HI) && last;

    assign freeze    = (mem_req & ~mem_ready_q) | (if_req & ~if_ready_q);
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    // Byte-lane bits and address bits above the SRAM are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+1], if_addr[1:0],
                                mem_addr[31:ADDR_W+1], mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_elig || if_elig) begin
                    state_d = LO;
                    cnt_d   = 4'd0;
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from registered state only, so they are stable across a phase.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'h0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (state_q == LO || state_q == HI) begin
            sram_addr = {addr_q, state_q == HI};
            if (wr_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
                sram_we_n   = last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            is_mem_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            lo_q     <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE) begin
                if (mem_elig) begin
                    is_mem_q <= 1'b1;
                    wr_q     <= mem_w_en;
                    addr_q   <= mem_addr[ADDR_W:2];
                    wdata_q  <= mem_wdata;
                end else if (if_elig) begin
                    is_mem_q <= 1'b0;
                    wr_q     <= 1'b0;
                    addr_q   <= if_addr[ADDR_W:2];
                end
            end
            if (state_q == LO && last && !wr_q)
                lo_q <= sram_dq_in;
        end
    end

    // Ready flags are set on entry to DONE and held until the pipeline unfreezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            if (done_hit && !is_mem_q)
                if_ready_q <= 1'b1;
            else if (!freeze)
                if_ready_q <= 1'b0;

            if (done_hit && is_mem_q)
                mem_ready_q <= 1'b1;
            else if (!freeze)
                mem_ready_q <= 1'b0;

            if (done_hit && !is_mem_q)
                if_rdata_q <= {sram_dq_in, lo_q};
            if (done_hit && is_mem_q && !wr_q)
                mem_rdata_q <= {sram_dq_in, lo_q};
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: drivers push expected words from a word-level memory model,
// a monitor pops and compares whenever a requester consumes its ready.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_r_en, mem_w_en;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ready, mem_ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    logic        b_if_req, b_zero;
    logic [31:0] b_if_addr, b_z32;
    logic [31:0] b_if_rdata, b_mem_rdata;
    logic        b_if_ready, b_mem_ready, b_freeze;
    logic [17:0] b_sram_addr;
    logic [15:0] b_dq_out, b_dq_in;
    logic        b_dq_oe, b_we_n, b_oe_n;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(18), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .freeze(freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_port_arbiter #(.ADDR_W(18), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .mem_r_en(b_zero), .mem_w_en(b_zero), .mem_addr(b_z32),
        .mem_wdata(b_z32), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
        .freeze(b_freeze), .sram_addr(b_sram_addr), .sram_dq_out(b_dq_out),
        .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in),
        .sram_we_n(b_we_n), .sram_oe_n(b_oe_n)
    );

    // Physical SRAM for the main DUT: 256 halfwords, preload port for the bench.
    logic [15:0] hw [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a  = 8'h0;
    logic [15:0] pre_d  = 16'h0;
    assign sram_dq_in = sram_oe_n ? 16'h0 : hw[sram_addr[7:0]];
    always @(posedge clk) begin
        if (pre_we)          hw[pre_a] <= pre_d;
        else if (!sram_we_n) hw[sram_addr[7:0]] <= sram_dq_out;
    end

    assign b_dq_in = b_oe_n ? 16'h0 :
                     (b_sram_addr == 18'd4) ? 16'h1111 :
                     (b_sram_addr == 18'd5) ? 16'h2222 : 16'h0;

    // Reference model: word memory, last loaded value, expected-response queues.
    logic [31:0] ref_word [0:127];
    logic [31:0] last_load;
    logic [31:0] if_q [$];
    logic [31:0] mem_q [$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pre_we = 1'b1; pre_a = 8'(a); pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic if_op(input int w);
        bit ok = 0;
        if_addr = (32'(w) << 2) | 32'($urandom_range(0, 3));
        if_q.push_back(ref_word[w]);
        if_req = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (if_ready && !freeze) begin ok = 1; break; end
        end
        if (!ok) chk("if_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // op: 0 read, 1 write, 2 read+write (behaves as write)
    task automatic mem_op(input int op, input int w, input logic [31:0] d);
        bit ok = 0;
        mem_addr  = (32'(w) << 2) | 32'($urandom_range(0, 3));
        mem_wdata = d;
        if (op == 0) begin
            mem_q.push_back(ref_word[w]);
            last_load = ref_word[w];
        end else begin
            mem_q.push_back(last_load);
            ref_word[w] = d;
        end
        mem_r_en = (op != 1);
        mem_w_en = (op != 0);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (mem_ready && !freeze) begin ok = 1; break; end
        end
        if (!ok) chk("mem_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pa, pb, pc;
        logic [17:0] ad [0:15];
        logic [15:0] old_hi;
        logic [31:0] w32;
        int cnt4, cnt5, bad;

        rst = 1'b1; if_req = 0; mem_r_en = 0; mem_w_en = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; last_load = 0;
        b_if_req = 0; b_if_addr = 0; b_zero = 0; b_z32 = 0;

        fork
            forever begin
                logic [31:0] e;
                @(negedge clk);
                if (!rst) begin
                    if (if_ready && !freeze) begin
                        if (if_q.size() == 0) chk("if_unexpected_ready", 32'd1, 32'd0);
                        else begin e = if_q.pop_front(); chk("if_rdata", if_rdata, e); end
                    end
                    if (mem_ready && !freeze) begin
                        if (mem_q.size() == 0) chk("mem_unexpected_ready", 32'd1, 32'd0);
                        else begin e = mem_q.pop_front(); chk("mem_rdata", mem_rdata, e); end
                    end
                end
            end
        join_none

        @(posedge clk); #1;
        for (int i = 0; i < 128; i++) begin
            w32 = $urandom;
            ref_word[i] = w32;
            preload(2*i, w32[15:0]);
            preload(2*i+1, w32[31:16]);
        end

        @(negedge clk);
        chk("reset_ready", {30'd0, if_ready, mem_ready}, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_mem_rdata", mem_rdata, 32'd0);
        chk("reset_strobes", {28'd0, sram_we_n, sram_oe_n, sram_dq_oe, freeze}, 32'b1100);
        chk("reset_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Lone fetch of word 2
        ref_word[2] = 32'hDEADBEEF;
        preload(4, 16'hBEEF);
        preload(5, 16'hDEAD);
        if_req = 1; if_addr = 32'h8;
        if_q.push_back(32'hDEADBEEF);
        pa = 0; pb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ad[k] = sram_addr; pa[k] = freeze; pb[k] = if_ready;
        end
        chk("fetch_rdata_c5", if_rdata, 32'hDEADBEEF);
        chk("fetch_addr_seq", {ad[1][7:0], ad[2][7:0], ad[3][7:0], ad[4][7:0]}, 32'h04040505);
        chk("fetch_freeze_pat", 32'(pa[5:0]), 32'h1F);
        chk("fetch_ready_pat", 32'(pb[5:0]), 32'h20);
        @(posedge clk); #1; if_req = 0;
        @(negedge clk);
        chk("fetch_ready_clear", 32'(if_ready), 32'd0);
        @(posedge clk); #1;

        // Store 0x12345678 to word 4; inputs scrambled after the grant edge
        mem_w_en = 1; mem_addr = 32'h10; mem_wdata = 32'h12345678;
        ref_word[4] = 32'h12345678;
        mem_q.push_back(last_load);
        pa = 0; pb = 0; pc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ad[k] = sram_addr; pa[k] = ~sram_we_n; pb[k] = sram_dq_oe; pc[k] = mem_ready;
            if (k == 0) begin @(posedge clk); #1; mem_addr = 32'h40; mem_wdata = 32'hFFFFFFFF; end
        end
        chk("store_we_pat", 32'(pa[5:0]), 32'h0A);
        chk("store_oe_pat", 32'(pb[5:0]), 32'h1E);
        chk("store_ready_pat", 32'(pc[5:0]), 32'h20);
        chk("store_addr", {16'd0, ad[1][7:0], ad[3][7:0]}, 32'h0809);
        @(posedge clk); #1; mem_w_en = 0;
        chk("store_hw8", 32'(hw[8]), 32'h5678);
        chk("store_hw9", 32'(hw[9]), 32'h1234);
        @(posedge clk); #1;

        // Contention: MEM read and IF fetch rise together
        if_req = 1; if_addr = 32'h8; mem_r_en = 1; mem_addr = 32'h10;
        mem_q.push_back(ref_word[4]); last_load = ref_word[4];
        if_q.push_back(ref_word[2]);
        pa = 0; pb = 0; pc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            pa[k] = mem_ready; pb[k] = if_ready; pc[k] = freeze;
        end
        chk("cont_mem_ready_pat", 32'(pa[11:0]), 32'hFE0);
        chk("cont_if_ready_pat", 32'(pb[11:0]), 32'h800);
        chk("cont_freeze_pat", 32'(pc[11:0]), 32'h7FF);
        @(posedge clk); #1; if_req = 0; mem_r_en = 0;
        @(negedge clk);
        chk("cont_ready_clear", {30'd0, if_ready, mem_ready}, 32'd0);
        @(posedge clk); #1;

        // Read+write together acts as a write; mem_rdata keeps the last load
        mem_op(2, 8, $urandom);

        // Fetch request dropped after one cycle still completes
        if_req = 1; if_addr = 32'h4;
        if_q.push_back(ref_word[1]);
        pa = 0;
        @(negedge clk); pa[0] = if_ready;
        @(posedge clk); #1; if_req = 0;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk); pa[k] = if_ready;
        end
        chk("drop_ready_pat", 32'(pa[6:0]), 32'h20);
        @(posedge clk); #1;

        // Reset during the LO phase of a write
        old_hi = hw[25];
        w32 = $urandom;
        mem_w_en = 1; mem_addr = 32'h30; mem_wdata = w32;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_we_low", 32'(sram_we_n), 32'd0);
        rst = 1;
        @(negedge clk);
        chk("midrst_strobes", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        chk("midrst_addr", 32'(sram_addr), 32'd0);
        chk("midrst_freeze", 32'(freeze), 32'd1);
        chk("midrst_rdata", if_rdata | mem_rdata, 32'd0);
        @(posedge clk); #1; rst = 0; mem_w_en = 0;
        chk("midrst_no_hi_write", 32'(hw[25]), 32'(old_hi));
        ref_word[12][15:0] = w32[15:0];
        last_load = 0;
        repeat (2) @(posedge clk); #1;

        // Randomized concurrent traffic: fetches from words 0..63, data in 64..127
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if_op($urandom_range(0, 63));
            end
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                mem_op($urandom_range(0, 2), $urandom_range(64, 127), $urandom);
            end
        join
        repeat (3) @(posedge clk); #1;
        chk("sb_if_drained", 32'(if_q.size()), 32'd0);
        chk("sb_mem_drained", 32'(mem_q.size()), 32'd0);

        bad = 0;
        for (int i = 0; i < 128; i++)
            if ({hw[2*i+1], hw[2*i]} !== ref_word[i]) bad++;
        chk("sram_image_mismatches", 32'(bad), 32'd0);

        // WAIT_CYCLES=3 instance: lone read
        b_if_req = 1; b_if_addr = 32'h8;
        pa = 0; cnt4 = 0; cnt5 = 0; bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pa[k] = b_if_ready;
            if (!b_oe_n && b_sram_addr == 18'd4) cnt4++;
            if (!b_oe_n && b_sram_addr == 18'd5) cnt5++;
            if (!b_we_n || b_dq_oe || b_dq_out != 16'h0 || b_mem_ready) bad++;
            if (k < 9 && !b_freeze) bad++;
        end
        chk("w3_ready_pat", 32'(pa[9:0]), 32'h200);
        chk("w3_rdata", b_if_rdata, 32'h22221111);
        chk("w3_oe_lo", 32'(cnt4), 32'd4);
        chk("w3_oe_hi", 32'(cnt5), 32'd4);
        chk("w3_misc", 32'(bad), 32'd0);
        chk("w3_mem_rdata", b_mem_rdata, 32'd0);
        @(posedge clk); #1; b_if_req = 0;
        repeat (12) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
